ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the mouse, e.g. 0xF4 "enable data reporting", 0xFF reset, or a sample-rate command. It drives the open-collector ps2_clk/ps2_data lines through output-enable pins and performs the request-to-send, bit-shift and ACK sequence. It sits beside the PS/2 mouse receiver in the clk_100 domain; the top level ties the pads as inout, driving 0 when an oe pin is set and Z otherwise.

---
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame shift, device ACK.
// Optional define PS2_TX_FILTER_EN inserts an 8-sample stability filter on ps2_clk ahead of edge detection.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_REL} state_t;

  state_t        state, state_nx;
  logic [10:0]   frame, frame_nx;
  logic [3:0]    idx, idx_nx;
  logic [IW-1:0] inh_cnt, inh_nx;
  logic [TW-1:0] to_cnt, to_nx;
  logic          done_nx, err_nx, data_oe_nx, to_hit;

  logic clk_s1, clk_s2, data_s1, data_s2, clk_lvl, clk_prev, fe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_prev <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      data_s1  <= ps2_data_i;
      data_s2  <= data_s1;
      clk_prev <= clk_lvl;
    end
  end

`ifdef PS2_TX_FILTER_EN
  logic       clk_filt;
  logic [2:0] filt_cnt;

  // Level follows the synchronised clock only after 8 consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == 3'd7) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign clk_lvl = clk_filt;
`else
  assign clk_lvl = clk_s2;
`endif

  assign fe     = clk_prev & ~clk_lvl;
  assign to_hit = (to_cnt == TO_LAST);

  // Handshake: tx_data is taken on a cycle where tx_valid and tx_ready are both high;
  // tx_valid is a don't-care whenever tx_ready is low.
  always_comb begin
    state_nx   = state;
    frame_nx   = frame;
    idx_nx     = idx;
    inh_nx     = inh_cnt;
    to_nx      = to_cnt;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    data_oe_nx = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          // Frame bit 0 is the start bit, so idx tracks the falling-edge count directly.
          frame_nx = {1'b1, ~^tx_data, tx_data, 1'b0};
          inh_nx   = '0;
          state_nx = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt == INH_LAST) state_nx = START;
        else                     inh_nx   = inh_cnt + 1'b1;
      end
      START: begin
        idx_nx   = '0;
        to_nx    = '0;
        state_nx = SEND;
      end
      SEND: begin
        if (to_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          to_nx = to_cnt + 1'b1;
          if (fe) begin
            idx_nx = idx + 1'b1;
            if (idx == 4'd9) state_nx = ACK;
          end
        end
      end
      ACK: begin
        if (to_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          to_nx = to_cnt + 1'b1;
          if (fe) begin
            if (data_s2) begin
              err_nx   = 1'b1;
              state_nx = IDLE;
            end else begin
              state_nx = WAIT_REL;
            end
          end
        end
      end
      WAIT_REL: begin
        if (to_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          to_nx = to_cnt + 1'b1;
          if (clk_lvl && data_s2) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    data_oe_nx = (state_nx == START) || ((state_nx == SEND) && !frame_nx[idx_nx]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      frame       <= '0;
      idx         <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      tx_ready    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      state       <= state_nx;
      frame       <= frame_nx;
      idx         <= idx_nx;
      inh_cnt     <= inh_nx;
      to_cnt      <= to_nx;
      tx_ready    <= (state_nx == IDLE);
      ps2_clk_oe  <= (state_nx == INHIBIT) || (state_nx == START);
      ps2_data_oe <= data_oe_nx;
      busy        <= (state_nx != IDLE);
      tx_done     <= done_nx;
      tx_err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus model, PS/2 device model and a completion scoreboard.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TOC  = 5000;
  localparam int HALF = 50;
`ifdef PS2_TX_FILTER_EN
  localparam int SYNC_LAT = 11;
  localparam bit GLITCH   = 1'b1;
`else
  localparam int SYNC_LAT = 3;
  localparam bit GLITCH   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  // Wired-AND bus: either side pulling low wins.
  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (clk_line),
    .ps2_data_i (data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  // Clock / cycle count
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state: record = {tx_done, tx_err, stop, parity, data[7:0]} as seen by the device
  int          total = 0;
  int          bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_act, mon_exp;
  logic [9:0]  cap;
  int          fe11_cyc, pulse_cyc;
  logic [2:0]  pulse_lines;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  // Driver: offer one byte; optionally push its expected record and keep tx_valid high.
  task automatic issue(input logic [7:0] b, input logic [11:0] exp, input bit push, input bit hold);
    int n;
    n = 0;
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) expire("wait_ready");
    tx_data  = b;
    tx_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Device model: waits for request-to-send, clocks n_clk bits, then ACKs (or NACKs) on clock 11.
  task automatic dev_frame(input bit ack, input int n_clk, input bit glitch);
    int n;
    n = 0;
    while (!(data_line == 1'b0 && clk_line == 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      expire("dev_rts");
      return;
    end
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 10 && k <= n_clk; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      cap[k-1] = data_line;
      if (glitch && k == 3) begin
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF / 2 - 3) @(negedge clk);
      end else begin
        repeat (HALF / 2) @(negedge clk);
      end
    end
    if (n_clk < 10) return;
    dev_data = ack ? 1'b0 : 1'b1;
    repeat (HALF / 2) @(negedge clk);
    dev_clk  = 1'b0;
    fe11_cyc = cyc;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    dev_data = 1'b1;
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: no finish within 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int fall_cyc;
    rst         = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    cap         = '0;
    fe11_cyc    = 0;
    pulse_cyc   = 0;
    pulse_lines = '0;

    // Monitor: every done/err pulse pops one expected record.
    fork
      forever begin
        @(negedge clk);
        if (rst && (tx_done || tx_err)) begin
          pulse_cyc   = cyc;
          pulse_lines = {ps2_clk_oe, ps2_data_oe, tx_ready};
          mon_act     = {tx_done, tx_err, cap};
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got %h with no entry queued", mon_act);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
              bad++;
              $display("FAIL scoreboard: got %h want %h", mon_act, mon_exp);
            end
          end
        end
      end
    join_none

    // Reset values
    repeat (4) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_err", tx_err, 0);
    check("rst_ready", tx_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1);

    // 0xF4: five ones -> parity 0, stop 1
    issue(8'hF4, 12'hAF4, 1'b1, 1'b0);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("start_len", n, 1);
    dev_frame(1'b1, 10, 1'b0);

    // 0xFF: eight ones -> parity 1 (line released at parity slot)
    issue(8'hFF, 12'hBFF, 1'b1, 1'b0);
    dev_frame(1'b1, 10, 1'b0);

    // NACK on 0x12 (two ones -> parity 1)
    issue(8'h12, 12'h712, 1'b1, 1'b0);
    dev_frame(1'b0, 10, 1'b0);
    @(negedge clk);
    check("nack_latency", pulse_cyc - fe11_cyc, SYNC_LAT);
    check("nack_lines", pulse_lines, 3'b001);

    // Device never clocks: timeout counted from ps2_clk_oe release
    cap = '0;
    issue(8'h00, 12'h400, 1'b1, 1'b0);
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    fall_cyc = cyc;
    n = 0;
    while (!tx_err && n < TOC + 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= TOC + 500) expire("timeout_err");
    @(negedge clk);
    check("timeout_latency", pulse_cyc - fall_cyc, TOC);
    check("timeout_lines", pulse_lines, 3'b001);

    // Reset while bit 4 is on the line, then a clean 0x55 (four ones -> parity 1)
    issue(8'h55, 12'h000, 1'b0, 1'b0);
    dev_frame(1'b1, 5, 1'b0);
    check("abort_busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_clk_oe", ps2_clk_oe, 0);
    check("abort_data_oe", ps2_data_oe, 0);
    check("abort_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", tx_ready, 1);
    issue(8'h55, 12'hB55, 1'b1, 1'b0);
    dev_frame(1'b1, 10, 1'b0);

    // tx_valid held with churning tx_data: only 0xA3 (four ones -> parity 1) goes out
    issue(8'hA3, 12'hBA3, 1'b1, 1'b1);
    fork
      dev_frame(1'b1, 10, GLITCH);
      for (int i = 0; i < 40; i++) begin
        tx_data = tx_data + 8'h1D;
        @(negedge clk);
      end
    join
    tx_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("idle_after_hold", busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
